cfg_chain_loader: RTL
=====================

# cfg_chain_loader

Bitstream loader that drives the serial configuration chain of the cell/switch/logic blocks. It accepts configuration words from a host-side stream and shifts them out bit-serially with the chain's enable asserted, pausing when the host stalls. After the load pass it can run an optional verify pass: the host re-streams the same words and the loader compares each bit against the bit returned at the chain's tail.

## Interface
- CHAIN_LEN, 20, total configuration bits in the chain (≥ 1)
- WORD_W, 8, host word width (≥ 1)
- prog_clk  in  1  clock; same clock as the chain's programming clock
- prog_rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; honoured only in IDLE
- verify_en  in  1  sampled with start; 1 = run the verify pass after the load pass
- abort  in  1  return to IDLE from any state
- word_data  in  WORD_W  configuration word; bit 0 is sent first
- word_valid  in  1  word_data valid
- word_ready  out  1  loader accepts word_data this cycle
- cfg_bit  out  1  drives chain prog_in
- cfg_en  out  1  drives chain prog_en
- cfg_ret  in  1  chain prog_out (registered tail bit)
- busy  out  1  high in LOAD and VERIFY
- done  out  1  one-cycle pulse on normal completion
- verify_fail  out  1  sticky mismatch flag; cleared by the next accepted start

## Operation
- Stream order: word 0 first, LSB first within each word. The first bit shifted ends at chain index 0.
- Words per pass: ceil(CHAIN_LEN/WORD_W). Bits of the final word beyond CHAIN_LEN are discarded and never shifted.
- FSM states: IDLE, LOAD, VERIFY, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> VERIFY after CHAIN_LEN shifts, if verify_en was latched; otherwise LOAD -> DONE.
  - VERIFY -> DONE after CHAIN_LEN shifts.
  - DONE -> IDLE unconditionally after one cycle. done is high in DONE.
  - abort from any state -> IDLE next edge, with no done pulse. verify_fail keeps its value.
- Serializer: one word register plus a bit index.
  - word_ready = busy and (register empty, or the register's last valid bit is being shifted this cycle). This allows back-to-back words with no bubble.
  - Do not accept a word beyond the pass's word count.
- cfg_en = 1 only when the register holds a valid bit in LOAD/VERIFY. An empty register means cfg_en = 0: no shift, counters hold.
- Shift counter runs 0..CHAIN_LEN-1 and increments on every cycle with cfg_en = 1. It resets to 0 at the pass boundary.
- Verify: in VERIFY, on every cycle with cfg_en = 1, check cfg_ret against cfg_bit. If they differ, set verify_fail. Because the chain is CHAIN_LEN long, the bit emerging at the tail during verify position k is load-pass bit k.
- The verify pass re-shifts identical data, so the chain content is unchanged by it.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0, word register empty.
- cfg_bit and cfg_en are registered. The chain shifts on the prog_clk edge following the cycle in which they are high.
- A word is accepted on the edge where word_valid and word_ready are both high.
  - First cfg_en = 1 is in the cycle after that acceptance edge.
  - Latency from start to first word_ready = 1 is one cycle.
- The final shift of a pass and the pass transition happen on the same edge; cfg_en is 0 in the first cycle of VERIFY/DONE.
- start when not IDLE is ignored. start and abort high together in IDLE: abort wins.
- Reset asserted mid-pass: outputs go to 0 immediately (asynchronous). The chain keeps a partial configuration; the host must reload.

## Structure
- Package cfg_chain_pkg holds:
  - the state enum (IDLE/LOAD/VERIFY/DONE);
  - a function for the words-per-pass count;
  - a function for the counter width, clog2(CHAIN_LEN+1).
- One sub-module, cfg_word_serializer: WORD_W parallel-in/serial-out with a valid-bit count and a last-bit flag. The top level holds the FSM, the shift counter and the verify compare.

## Test plan
- CHAIN_LEN=20, WORD_W=8, no verify, words 0xA5, 0x3C, 0x0F with word_valid always high -> exactly 20 cfg_en cycles, no gaps. Bit sequence: 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. Upper nibble of 0x0F not shifted. done pulses once.
- Same load, but word_valid low for 3 cycles between words 1 and 2 -> cfg_en low for those cycles, identical bit sequence, shift counter holds.
- Verify with a 20-bit behavioral chain model, words re-streamed identically -> 40 shifts total, verify_fail = 0, chain content unchanged.
- Verify with the 2nd-pass word 1 changed to 0x3D -> verify_fail = 1 from the cycle after bit 8 of VERIFY and stays set through DONE. The next start clears it.
- abort after 5 shifts -> IDLE next cycle, cfg_en = 0, no done, word_ready = 0. A subsequent start restarts from bit 0.
- prog_rst_n low mid-LOAD -> all outputs 0 asynchronously. After release, a start performs a full 20-bit load.

Source files
------------

// File: rtl/cfg_chain_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package cfg_chain_pkg;

   // Loader sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_DONE   = 2'd3
   } cfg_state_e;

   // Host words needed to cover the whole chain in one pass.
   function automatic int words_per_pass(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   // Width of a counter able to hold 0..chain_len.
   function automatic int cnt_width(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

   // Number of bits of the final word that actually land in the chain.
   function automatic int last_word_bits(input int chain_len, input int word_w);
      return chain_len - (words_per_pass(chain_len, word_w) - 1) * word_w;
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Parallel-in / serial-out word register, LSB first, with a count of the
// valid bits still to be shifted and a flag marking the final valid bit.
module cfg_word_serializer #(
   parameter int WORD_W = 8,
   parameter int NB_W   = $clog2(WORD_W + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic [NB_W-1:0]   nbits_i,
   input  logic              shift_i,
   output logic              bit_o,
   output logic              valid_o,
   output logic              last_o
);

   logic [WORD_W-1:0] data_q, data_d;
   logic [NB_W-1:0]   cnt_q, cnt_d;

   // Next register contents: a load wins over a shift so that a new word can
   // replace the one whose last bit is leaving in the same cycle.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (load_i) begin
         data_d = data_i;
         cnt_d  = nbits_i;
      end else if (shift_i && (cnt_q != '0)) begin
         data_d = data_q >> 1;
         cnt_d  = cnt_q - 1'b1;
      end
   end

   // Word register and remaining-bit count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bit_o   = data_q[0];
   assign valid_o = (cnt_q != '0);
   assign last_o  = (cnt_q == NB_W'(1));

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial configuration chain loader: streams host words into the chain
// LSB first and optionally re-streams them to compare against the chain tail.
//
// Host handshake: a word is taken on the clock edge where word_valid and
// word_ready are both high; word_data must be stable while word_valid is high
// and not yet accepted. word_ready never depends on word_valid.
module cfg_chain_loader
   import cfg_chain_pkg::*;
#(
   parameter int CHAIN_LEN = 20,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              verify_en,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              cfg_bit,
   output logic              cfg_en,
   input  logic              cfg_ret,
   output logic              busy,
   output logic              done,
   output logic              verify_fail
);

   localparam int WPP       = words_per_pass(CHAIN_LEN, WORD_W);
   localparam int CNT_W     = cnt_width(CHAIN_LEN);
   localparam int WC_W      = $clog2(WPP + 1);
   localparam int NB_W      = $clog2(WORD_W + 1);
   localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);

   cfg_state_e       state_q, state_d;
   logic             verify_q, verify_d;
   logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
   logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
   logic             verify_fail_q, verify_fail_d;

   logic             in_pass;
   logic             in_verify;
   logic             in_done;
   logic             ser_bit, ser_valid, ser_last;
   logic             shift_fire;
   logic             pass_end;
   logic             start_ok;
   logic             accept;
   logic [NB_W-1:0]  load_nbits;

   assign start_ok   = (state_q == ST_IDLE) && start && !abort;
   assign shift_fire = in_pass && ser_valid;
   assign pass_end   = shift_fire && (shift_cnt_q == CNT_W'(CHAIN_LEN - 1));
   assign word_ready = in_pass && (word_cnt_q < WC_W'(WPP))
                       && (!ser_valid || (ser_last && shift_fire));
   assign accept     = word_ready && word_valid;
   assign load_nbits = (word_cnt_q == WC_W'(WPP - 1)) ? NB_W'(LAST_BITS) : NB_W'(WORD_W);

   cfg_word_serializer #(
      .WORD_W (WORD_W),
      .NB_W   (NB_W)
   ) u_ser (
      .clk_i   (prog_clk),
      .rst_ni  (prog_rst_n),
      .clear_i (abort),
      .load_i  (accept),
      .data_i  (word_data),
      .nbits_i (load_nbits),
      .shift_i (shift_fire),
      .bit_o   (ser_bit),
      .valid_o (ser_valid),
      .last_o  (ser_last)
   );

   // FSM state register.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: abort dominates; passes end on their final shift edge.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   if (pass_end) state_d = verify_q ? ST_VERIFY : ST_DONE;
            ST_VERIFY: if (pass_end) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      in_pass   = 1'b0;
      in_verify = 1'b0;
      in_done   = 1'b0;
      case (state_q)
         ST_LOAD:   in_pass = 1'b1;
         ST_VERIFY: begin
            in_pass   = 1'b1;
            in_verify = 1'b1;
         end
         ST_DONE:   in_done = 1'b1;
         default:   ;
      endcase
   end

   // Pass bookkeeping and the sticky verify result.
   always_comb begin
      shift_cnt_d   = shift_cnt_q;
      word_cnt_d    = word_cnt_q;
      verify_d      = verify_q;
      verify_fail_d = verify_fail_q;
      if (abort || start_ok || pass_end) begin
         shift_cnt_d = '0;
         word_cnt_d  = '0;
      end else begin
         if (shift_fire) shift_cnt_d = shift_cnt_q + 1'b1;
         if (accept)     word_cnt_d  = word_cnt_q + 1'b1;
      end
      if (start_ok) begin
         verify_d      = verify_en;
         verify_fail_d = 1'b0;
      end else if (!abort && in_verify && shift_fire && (cfg_ret != ser_bit)) begin
         verify_fail_d = 1'b1;
      end
   end

   // Counter, mode and verify flag registers.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         shift_cnt_q   <= '0;
         word_cnt_q    <= '0;
         verify_q      <= 1'b0;
         verify_fail_q <= 1'b0;
      end else begin
         shift_cnt_q   <= shift_cnt_d;
         word_cnt_q    <= word_cnt_d;
         verify_q      <= verify_d;
         verify_fail_q <= verify_fail_d;
      end
   end

   assign busy        = in_pass;
   assign done        = in_done;
   assign cfg_en      = shift_fire;
   assign cfg_bit     = shift_fire & ser_bit;
   assign verify_fail = verify_fail_q;

endmodule
